tx_result_scheduler: RTL
========================

TX_RESULT_SCHEDULER -- requirements
Module: tx_result_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of result requesters (2..8).
REQ-002 The block SHALL have parameter WORD_BYTES, default 64, giving the payload bytes per request (512-bit word).
REQ-003 The block SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port req  in  N_REQ  per-requester transmit request, level, held until ack.
REQ-006 The block SHALL have port data  in  N_REQ*8*WORD_BYTES  flattened payloads; requester i occupies slice i.
REQ-007 The block SHALL have port grant  out  N_REQ  one-hot, high for the requester whose frame is in flight.
REQ-008 The block SHALL have port ack  out  N_REQ  one-cycle pulse when requester i's frame has fully completed.
REQ-009 The block SHALL have port tx_avail  out  1  one-cycle byte-valid strobe to the UART byte transmitter.
REQ-010 The block SHALL have port tx_byte  out  8  byte presented to the transmitter, stable from strobe until tx_done.
REQ-011 The block SHALL have port tx_done  in  1  one-cycle pulse from the transmitter when the current byte has finished.
REQ-012 The block SHALL have port busy  out  1  high from grant until the ack cycle inclusive.

Function
REQ-013 The FSM SHALL have states IDLE, ARB, HDR, LOAD, STROBE, WAIT, ACK.
REQ-014 IDLE: if any req bit is high, go to ARB next cycle; else stay.
REQ-015 ARB: select the first asserted req at or after pointer rr_ptr, wrapping modulo N_REQ; set grant one-hot; capture that requester's data slice into an internal shadow register; clear byte counter; go to HDR.
REQ-016 ARB with no req asserted (request withdrawn) SHALL return to IDLE with grant all-zero and no ack.
REQ-017 HDR: drive tx_byte = {4'hA, 1'b0, 3-bit requester index}; go to STROBE.
REQ-018 LOAD: drive tx_byte = shadow byte at byte counter, LSB byte (bits 7:0) first; go to STROBE.
REQ-019 STROBE: assert tx_avail for exactly one cycle; go to WAIT.
REQ-020 WAIT: tx_avail low; on tx_done, if header just sent go to LOAD with counter 0; else if counter == WORD_BYTES-1 go to ACK; else increment counter and go to LOAD.
REQ-021 tx_done SHALL be ignored in every state except WAIT.
REQ-022 ACK: pulse ack bit of the granted requester for one cycle, clear grant, set rr_ptr = granted index + 1 modulo N_REQ, go to IDLE.
REQ-023 One frame SHALL be 1 + WORD_BYTES bytes; bytes never reorder or repeat.
REQ-024 Changes on data or req of any requester after the ARB cycle SHALL not affect the frame in flight.
REQ-025 Requests arriving during a frame SHALL be served only after ACK, in round-robin order from rr_ptr.
REQ-026 Starvation bound: a continuously asserted req SHALL be granted within N_REQ-1 frames of other requesters.
REQ-027 Latency: from req rising in IDLE to first tx_avail SHALL be 4 cycles (IDLE, ARB, HDR, STROBE).
REQ-028 The byte counter SHALL be wide enough for WORD_BYTES-1 and never wrap within a frame.

Reset
REQ-029 When reset is low, asynchronously: state = IDLE, grant = 0, ack = 0, tx_avail = 0, tx_byte = 8'h00, busy = 0, rr_ptr = 0, counter = 0.
REQ-030 Reset mid-frame SHALL abandon the frame without an ack; after release the block resumes from IDLE with rr_ptr = 0.
REQ-031 Outputs SHALL not change on the first clock edge after reset release unless req is already high, which moves the FSM to ARB.

Verification
REQ-032 Single req: req=4'b0001, data[511:0]=bytes 0x00..0x3F, tx_done 10 cycles after each strobe -> header 0xA0, then 0x00..0x3F in order, ack[0] pulses once, busy then falls.
REQ-033 Contention: req=4'b1111 held from reset release -> grant order 0,1,2,3,0; headers 0xA0,0xA1,0xA2,0xA3.
REQ-034 Data change after grant: overwrite data slice 2 one cycle after grant[2] -> transmitted bytes equal the original slice.
REQ-035 Spurious tx_done pulsed during HDR or STROBE -> ignored; the byte count stays at 65 strobes per frame.
REQ-036 Reset low during byte 30 of a frame -> tx_avail, grant, busy at 0 immediately; no ack; the next req=4'b0100 is granted to requester 2 with rr_ptr restarting at 0.
REQ-037 Withdrawn request: req pulsed high for one cycle in IDLE, low in ARB -> return to IDLE, no tx_avail, no ack.

Source files
------------

// File: rtl/tx_result_scheduler.sv
// Round-robin scheduler that frames one requester's result word as a header byte
// plus WORD_BYTES payload bytes and hands them one at a time to a UART byte transmitter.
module tx_result_scheduler #(
    parameter int N_REQ      = 4,
    parameter int WORD_BYTES = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*8*WORD_BYTES-1:0] data,
    output logic [N_REQ-1:0]              grant,
    output logic [N_REQ-1:0]              ack,
    output logic                          tx_avail,
    output logic [7:0]                    tx_byte,
    input  logic                          tx_done,
    output logic                          busy
);

    localparam int SHW   = 8 * WORD_BYTES;
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {IDLE, ARB, HDR, LOAD, STROBE, WAIT, ACK} state_t;

    state_t           state;
    logic [2:0]       rr_ptr;
    logic [2:0]       cur_idx;
    logic [SHW-1:0]   shadow;
    logic [CNT_W-1:0] cnt;
    logic             hdr_phase;

    logic [7:0]       req_ext;
    logic [2:0]       cand;
    logic [2:0]       sel_idx;
    logic             sel_found;
    logic [CNT_W-1:0] load_cnt;
    logic [7:0]       next_byte;

    assign req_ext = 8'(req);

    // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cand      = 3'd0;
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 3'((int'(rr_ptr) + k) % N_REQ);
            if (!sel_found && req_ext[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // The first payload byte follows the header; afterwards the counter advances by one.
    assign load_cnt  = hdr_phase ? '0 : cnt + 1'b1;
    assign next_byte = 8'(shadow >> {load_cnt, 3'b000});

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            ack       <= '0;
            tx_avail  <= 1'b0;
            tx_byte   <= 8'h00;
            busy      <= 1'b0;
            rr_ptr    <= 3'd0;
            cur_idx   <= 3'd0;
            shadow    <= '0;
            cnt       <= '0;
            hdr_phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) state <= ARB;
                end
                ARB: begin
                    if (sel_found) begin
                        grant     <= N_REQ'(8'd1 << sel_idx);
                        cur_idx   <= sel_idx;
                        busy      <= 1'b1;
                        shadow    <= SHW'(data >> (SHW * int'(sel_idx)));
                        cnt       <= '0;
                        hdr_phase <= 1'b1;
                        tx_byte   <= {4'hA, 1'b0, sel_idx};
                        state     <= HDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                HDR, LOAD: begin
                    tx_avail <= 1'b1;
                    state    <= STROBE;
                end
                STROBE: begin
                    tx_avail <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (hdr_phase || cnt != LAST_CNT) begin
                            hdr_phase <= 1'b0;
                            cnt       <= load_cnt;
                            tx_byte   <= next_byte;
                            state     <= LOAD;
                        end else begin
                            ack   <= grant;
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    ack    <= '0;
                    grant  <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (cur_idx == 3'(N_REQ - 1)) ? 3'd0 : cur_idx + 3'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
